// File: rtl/jtopl_op_sinexp_pkg.sv
// jtopl_op_sinexp_pkg: shared waveform codes, widths and ROM content functions for the operator stage
package jtopl_op_sinexp_pkg;
  typedef enum logic [1:0] {WAV_SINE, WAV_HALF, WAV_ABS, WAV_PULSE} wav_e;
  localparam logic [12:0] ATT_MAX = 13'h1FFF;
  localparam int LSIN_W = 12;
  localparam int EXP_W = 10;
  localparam int OP_LAT = 3;
  localparam real PI = 3.14159265358979323846;
  function automatic int lsin_val(input int i);
    return $rtoi(-$ln($sin((real'(i) + 0.5) * PI / 512.0)) / $ln(2.0) * 256.0 + 0.5);
  endfunction
  function automatic int exp_val(input int i);
    return $rtoi(($pow(2.0, real'(i) / 256.0) - 1.0) * 1024.0 + 0.5);
  endfunction
endpackage

// File: rtl/jtopl_op_rom.sv
// jtopl_op_rom: synchronous-read log-sine and exponent tables, advanced by the operator enable
module jtopl_op_rom
  import jtopl_op_sinexp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic [7:0]        lsin_addr,
  input  logic [7:0]        exp_addr,
  output logic [LSIN_W-1:0] lsin,
  output logic [EXP_W-1:0]  exp_out
);
  logic [LSIN_W-1:0] lsin_tab [256];
  logic [EXP_W-1:0]  exp_tab  [256];
  for (genvar i = 0; i < 256; i++) begin : g_tab
    assign lsin_tab[i] = LSIN_W'(lsin_val(i));
    assign exp_tab[i]  = EXP_W'(exp_val(i));
  end
  always_ff @(posedge clk)
    if (rst) begin
      lsin    <= '0;
      exp_out <= '0;
    end else if (cen) begin
      lsin    <= lsin_tab[lsin_addr];
      exp_out <= exp_tab[exp_addr];
    end
endmodule

// File: rtl/jtopl_op_sinexp.sv
// jtopl_op_sinexp: phase modulation, waveform shaping, log-sine/exp conversion and feedback history
module jtopl_op_sinexp
  import jtopl_op_sinexp_pkg::*;
#(
  parameter int CH = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cenop,
  input  logic [9:0]  phase_IV,
  input  logic [9:0]  eg_V,
  input  logic [1:0]  wavsel_IV,
  input  logic [3:0]  ch_IV,
  input  logic        op_IV,
  input  logic        con_IV,
  input  logic [2:0]  fb_IV,
  output logic [12:0] op_VII,
  output logic        opsel_VII,
  output logic [3:0]  ch_VII
);
  logic signed [12:0] h1 [CH];
  logic signed [12:0] h2 [CH];
  logic signed [13:0] hsum;
  logic [9:0] pm_mod, pm, ph;
  logic [7:0] lsin_addr, exp_addr;
  logic [LSIN_W-1:0] lsin_V;
  logic [EXP_W-1:0] exp_VI;
  logic sign_IV, sil_IV, sign_V, aud_V, op_V, sign_VI, nz_VI, op_VI;
  logic [3:0] ch_V, ch_VI;
  logic [13:0] sum_V;
  logic [12:0] att_V;
  logic [4:0] sh_VI;
  logic [11:0] mag_VI;
  logic [12:0] res_VI;
  always_comb begin
    hsum = ch_IV < 4'(CH) ? 14'(h1[ch_IV]) + 14'(h2[ch_IV]) : '0;
    pm_mod = fb_IV == 3'd0 ? 10'd0 : 10'(hsum >>> (4'd9 - {1'b0, fb_IV}));
    pm = op_IV ? (con_IV ? 10'd0 : op_VII[10:1]) : pm_mod;
    ph = phase_IV + pm;
    lsin_addr = ph[8] ? ~ph[7:0] : ph[7:0];
    sil_IV = (wavsel_IV == WAV_HALF && ph[9]) || (wavsel_IV == WAV_PULSE && ph[8]);
    sign_IV = ph[9] && !wavsel_IV[1];
    sum_V = {2'b0, lsin_V} + {1'b0, eg_V, 3'b0};
    att_V = (!aud_V || sum_V[13]) ? ATT_MAX : sum_V[12:0];
    exp_addr = ~att_V[7:0];
    mag_VI = nz_VI ? {1'b1, exp_VI, 1'b0} >> sh_VI : '0;
    res_VI = sign_VI ? -{1'b0, mag_VI} : {1'b0, mag_VI};
  end
  jtopl_op_rom u_rom (
    .clk       (clk),
    .rst       (rst),
    .cen       (cenop),
    .lsin_addr (lsin_addr),
    .exp_addr  (exp_addr),
    .lsin      (lsin_V),
    .exp_out   (exp_VI)
  );
  // aud_V and nz_VI reset low so flushed stages emit exact zeros
  always_ff @(posedge clk)
    if (rst) begin
      sign_V    <= 1'b0;
      aud_V     <= 1'b0;
      op_V      <= 1'b0;
      ch_V      <= '0;
      sign_VI   <= 1'b0;
      nz_VI     <= 1'b0;
      sh_VI     <= '0;
      op_VI     <= 1'b0;
      ch_VI     <= '0;
      op_VII    <= '0;
      opsel_VII <= 1'b0;
      ch_VII    <= '0;
    end else if (cenop) begin
      sign_V    <= sign_IV;
      aud_V     <= !sil_IV;
      op_V      <= op_IV;
      ch_V      <= ch_IV;
      sign_VI   <= sign_V;
      nz_VI     <= att_V[12:8] < 5'd11;
      sh_VI     <= att_V[12:8];
      op_VI     <= op_V;
      ch_VI     <= ch_V;
      op_VII    <= res_VI;
      opsel_VII <= op_VI;
      ch_VII    <= ch_VI;
    end
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        h1[i] <= '0;
        h2[i] <= '0;
      end
    end else if (cenop && !opsel_VII && ch_VII < 4'(CH)) begin
      h1[ch_VII] <= op_VII;
      h2[ch_VII] <= h1[ch_VII];
    end
endmodule

// File: tb/tb_jtopl_op_sinexp.sv
// tb_jtopl_op_sinexp: directed checks of waveform, attenuation, FM, feedback and pipeline timing
module tb_jtopl_op_sinexp;
  import jtopl_op_sinexp_pkg::*;
  logic clk = 1'b0, rst = 1'b1, cenop = 1'b1;
  logic [9:0] phase_IV = '0, eg_V = '0;
  logic [1:0] wavsel_IV = '0;
  logic [3:0] ch_IV = 4'd1;
  logic op_IV = 1'b1, con_IV = 1'b1;
  logic [2:0] fb_IV = '0;
  logic [12:0] op_VII;
  logic opsel_VII;
  logic [3:0] ch_VII;
  int checks = 0, errors = 0;

  jtopl_op_sinexp dut (
    .clk(clk), .rst(rst), .cenop(cenop), .phase_IV(phase_IV), .eg_V(eg_V),
    .wavsel_IV(wavsel_IV), .ch_IV(ch_IV), .op_IV(op_IV), .con_IV(con_IV),
    .fb_IV(fb_IV), .op_VII(op_VII), .opsel_VII(opsel_VII), .ch_VII(ch_VII)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic [9:0] ph, input logic [1:0] w, input logic [3:0] ch,
                      input logic op, input logic con, input logic [2:0] fb);
    phase_IV = ph; wavsel_IV = w; ch_IV = ch; op_IV = op; con_IV = con; fb_IV = fb;
  endtask

  task automatic run(input logic [9:0] ph, input logic [1:0] w, input logic [9:0] eg);
    slot(ph, w, 4'd1, 1'b1, 1'b1, 3'd0);
    eg_V = eg;
    repeat (OP_LAT) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; cenop = 1'b1; eg_V = '0;
    slot(10'h000, 2'd0, 4'd1, 1'b1, 1'b1, 3'd0);
    repeat (4) tick();
    rst = 1'b0;
  endtask

  task automatic sweep(input logic [2:0] fb, output logic [12:0] out);
    out = '0;
    for (int s = 0; s < 18; s++) begin
      if (s == 0) slot(10'h100, 2'd0, 4'd0, 1'b0, 1'b0, fb);
      else slot(10'h000, 2'd0, 4'd1, 1'b1, 1'b1, 3'd0);
      tick();
      if (s == 2) out = op_VII;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; eg_V = '0;
    slot(10'h100, 2'd0, 4'd1, 1'b1, 1'b1, 3'd0);
    repeat (4) tick();
    checks++; if (op_VII !== 13'd0) begin errors++; $display("FAIL reset_op: got %0d expected 0", op_VII); end
    checks++; if (dut.h1[0] !== 13'd0 || dut.h2[0] !== 13'd0) begin errors++; $display("FAIL reset_hist: got %0d/%0d expected 0/0", dut.h1[0], dut.h2[0]); end
    rst = 1'b0;
    tick();
    checks++; if (op_VII !== 13'd0) begin errors++; $display("FAIL flush1: got %0d expected 0", op_VII); end
    tick();
    checks++; if (op_VII !== 13'd0) begin errors++; $display("FAIL flush2: got %0d expected 0", op_VII); end
    tick();
    checks++; if (op_VII !== 13'd4084) begin errors++; $display("FAIL first_slot: got %0d expected 4084", $signed(op_VII)); end
    checks++; if (opsel_VII !== 1'b1 || ch_VII !== 4'd1) begin errors++; $display("FAIL first_tags: got %0d/%0d expected 1/1", opsel_VII, ch_VII); end
  endtask

  task automatic test_peak();
    run(10'h100, 2'd0, 10'd0);
    checks++; if (op_VII !== 13'd4084) begin errors++; $display("FAIL peak_pos: got %0d expected 4084", $signed(op_VII)); end
    run(10'h300, 2'd0, 10'd0);
    checks++; if (op_VII !== 13'(-4084)) begin errors++; $display("FAIL peak_neg: got %0d expected -4084", $signed(op_VII)); end
    run(10'h000, 2'd0, 10'd0);
    checks++; if (op_VII !== 13'd12) begin errors++; $display("FAIL zero_phase: got %0d expected 12", $signed(op_VII)); end
  endtask

  task automatic test_waveform();
    logic [9:0] ph [6] = '{10'h300, 10'h100, 10'h300, 10'h140, 10'h0FF, 10'h2FF};
    logic [1:0] w [6] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [12:0] exp_v [6] = '{13'd0, 13'd4084, 13'd4084, 13'd0, 13'd4084, 13'd4084};
    for (int i = 0; i < 6; i++) begin
      run(ph[i], w[i], 10'd0);
      checks++; if (op_VII !== exp_v[i]) begin errors++; $display("FAIL wave%0d: got %0d expected %0d", i, $signed(op_VII), $signed(exp_v[i])); end
    end
  endtask

  task automatic test_atten();
    logic [9:0] ph [4] = '{10'h100, 10'h100, 10'h300, 10'h100};
    logic [9:0] eg [4] = '{10'h3FF, 10'h020, 10'h020, 10'h058};
    logic [12:0] exp_v [4] = '{13'd0, 13'd2042, 13'(-2042), 13'd607};
    for (int i = 0; i < 4; i++) begin
      run(ph[i], 2'd0, eg[i]);
      checks++; if (op_VII !== exp_v[i]) begin errors++; $display("FAIL atten%0d: got %0d expected %0d", i, $signed(op_VII), $signed(exp_v[i])); end
    end
  endtask

  task automatic test_fm();
    do_reset();
    eg_V = 10'h060;
    slot(10'h100, 2'd0, 4'd0, 1'b0, 1'b0, 3'd0); tick();
    slot(10'h000, 2'd0, 4'd1, 1'b1, 1'b1, 3'd0); tick();
    tick();
    checks++; if (op_VII !== 13'd510 || opsel_VII !== 1'b0) begin errors++; $display("FAIL fm_mod: got %0d/%0d expected 510/0", $signed(op_VII), opsel_VII); end
    slot(10'h000, 2'd0, 4'd0, 1'b1, 1'b0, 3'd0); tick();
    checks++; if (op_VII !== 13'd0) begin errors++; $display("FAIL fm_additive: got %0d expected 0", $signed(op_VII)); end
    slot(10'h000, 2'd0, 4'd1, 1'b1, 1'b1, 3'd0); tick();
    tick();
    checks++; if (op_VII !== 13'd510 || ch_VII !== 4'd0) begin errors++; $display("FAIL fm_car: got %0d ch %0d expected 510 ch 0", $signed(op_VII), ch_VII); end
  endtask

  task automatic test_feedback();
    logic [12:0] o;
    logic [12:0] s7 [3] = '{13'd4084, 13'd4084, 13'd4084};
    logic [12:0] s1 [3] = '{13'd4084, 13'd4062, 13'd4008};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sweep(3'd7, o);
      checks++; if (o !== s7[i]) begin errors++; $display("FAIL fb7_sweep%0d: got %0d expected %0d", i, $signed(o), s7[i]); end
      if (i == 1) begin
        checks++; if (dut.h1[0] !== 13'sd4084 || dut.h2[0] !== 13'sd4084) begin errors++; $display("FAIL fb7_hist: got %0d/%0d expected 4084/4084", dut.h1[0], dut.h2[0]); end
      end
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sweep(3'd1, o);
      checks++; if (o !== s1[i]) begin errors++; $display("FAIL fb1_sweep%0d: got %0d expected %0d", i, $signed(o), s1[i]); end
    end
    cenop = 1'b0;
    phase_IV = 10'h3AB; eg_V = 10'h155;
    repeat (5) tick();
    checks++; if (dut.h1[0] !== 13'sd4008 || dut.h2[0] !== 13'sd4062) begin errors++; $display("FAIL fb_gap_hist: got %0d/%0d expected 4008/4062", dut.h1[0], dut.h2[0]); end
    cenop = 1'b1; eg_V = '0;
  endtask

  task automatic test_gap();
    int nz;
    do_reset();
    run(10'h300, 2'd0, 10'd0);
    slot(10'h100, 2'd0, 4'd1, 1'b1, 1'b1, 3'd0); tick();
    cenop = 1'b0; phase_IV = 10'h000; eg_V = 10'h3FF;
    repeat (5) tick();
    checks++; if (op_VII !== 13'(-4084)) begin errors++; $display("FAIL gap_hold: got %0d expected -4084", $signed(op_VII)); end
    cenop = 1'b1; eg_V = '0; phase_IV = 10'h300;
    tick(); tick();
    checks++; if (op_VII !== 13'd4084) begin errors++; $display("FAIL gap_resume: got %0d expected 4084", $signed(op_VII)); end
    do_reset();
    slot(10'h100, 2'd0, 4'd12, 1'b0, 1'b0, 3'd0); tick();
    slot(10'h000, 2'd0, 4'd1, 1'b1, 1'b1, 3'd0); tick(); tick();
    checks++; if (op_VII !== 13'd4084 || ch_VII !== 4'd12) begin errors++; $display("FAIL bad_ch_out: got %0d ch %0d expected 4084 ch 12", $signed(op_VII), ch_VII); end
    tick();
    nz = 0;
    for (int i = 0; i < 9; i++) if (dut.h1[i] !== 13'sd0 || dut.h2[i] !== 13'sd0) nz++;
    checks++; if (nz !== 0) begin errors++; $display("FAIL bad_ch_hist: got %0d nonzero entries expected 0", nz); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] ph [4] = '{10'h100, 10'h300, 10'h300, 10'h300};
    logic [1:0] w [4] = '{2'd0, 2'd0, 2'd2, 2'd1};
    logic [12:0] exp_v [4] = '{13'd4084, 13'(-4084), 13'd4084, 13'd0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) slot(ph[i], w[i], 4'(i), 1'b1, 1'b1, 3'd0);
      tick();
      if (i >= 2) begin
        checks++; if (op_VII !== exp_v[i-2] || ch_VII !== 4'(i-2)) begin errors++; $display("FAIL b2b%0d: got %0d ch %0d expected %0d ch %0d", i-2, $signed(op_VII), ch_VII, $signed(exp_v[i-2]), i-2); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_peak();
    test_waveform();
    test_atten();
    test_fm();
    test_feedback();
    test_gap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
